stream_mux_arb: RTL and testbench
=================================

// Module: stream_mux_arb
//
// PURPOSE
//  - N-channel registered stream multiplexer with valid/ready handshakes and built-in arbitration.
//  - Generalises the fixed 4:1 combinational data mux: any channel count and data width.
//  - The select is produced internally from the channel requests, not by an external sel input.
//  - Sits between several producer streams and one shared consumer.
//  - Result is registered: 1-cycle latency, full throughput.
//
// PARAMETERS
//  - N_CH    4  number of input channels (>= 2)
//  - DATA_W  4  data width per channel (>= 1)
//  - ID_W    = $clog2(N_CH), derived localparam; width of the channel index
//
// PORTS
//  - clk        in   1              clock; all logic on posedge
//  - rst        in   1              synchronous, active-high reset
//  - in_valid   in   N_CH           per-channel request; bit i = channel i
//  - in_data    in   N_CH*DATA_W    packed data; channel i at [i*DATA_W +: DATA_W]
//  - in_ready   out  N_CH           per-channel accept; combinational
//  - out_valid  out  1              output holds a valid word
//  - out_data   out  DATA_W         registered selected data
//  - out_id     out  ID_W           index of the channel that supplied out_data
//  - out_ready  in   1              consumer accepts the word this cycle
//
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_id=0, priority pointer ptr=0, in_ready=0.
//    Reset asserted mid-transfer discards the held word with no output handshake.
//  - Transfer rule: a transfer on any port occurs when valid && ready are both 1 at posedge.
//  - slot_free = !out_valid || out_ready.
//  - Grant: exactly one channel g is granted when any in_valid bit is set, else none.
//  - Ready: in_ready[i] = slot_free && (i == g) && in_valid[i].
//    - At most one in_ready bit is high.
//    - in_ready never depends on in_data.
//  - Capture on a channel transfer:
//    - out_data <= in_data[g]
//    - out_id   <= g
//    - out_valid <= 1
//  - Drain: on an output transfer with no new capture, out_valid <= 0.
//    - out_data and out_id hold their last values.
//  - Simultaneous drain and capture in the same cycle:
//    - out_valid stays 1 and the new word replaces the old one.
//    - Sustains 1 word/cycle.
//  - Backpressure: while out_valid && !out_ready:
//    - out_data and out_id are held stable.
//    - All in_ready bits are 0.
//  - Latency: input transfer at edge k gives out_valid=1 from edge k onward.
//    The word is visible in the cycle after acceptance.
//  - Arbitration (round-robin mode):
//    - g is the first set in_valid bit scanning ptr, ptr+1, ... modulo N_CH.
//    - After a channel transfer from g, ptr <= (g+1) mod N_CH, wrapping N_CH-1 -> 0.
//    - With no transfer, ptr holds.
//  - A channel whose in_valid drops before it is granted loses its turn.
//    No request state is stored.
//
// CONFIGURATION
//  - Macro STREAM_MUX_ARB_RR_EN selects the arbitration policy.
//  - Defined: round-robin arbitration as above; ptr register present.
//  - Undefined: fixed priority.
//    - g is the lowest-index channel with in_valid set.
//    - No ptr register.
//    - Channel 0 can starve the others.
//  - Ports, latency and handshake rules are identical in both builds.
//
// TESTING
//  1. rst=1 for 2 cycles with in_valid=4'hF -> out_valid=0, out_data=0, out_id=0, in_ready=0.
//  2. Single request in_valid=4'b0100, in_data ch2=4'hA, out_ready=1
//     -> in_ready=4'b0100; next cycle out_valid=1, out_data=4'hA, out_id=2.
//  3. in_valid=4'hF held, out_ready=1 for 8 cycles
//     -> RR build: out_id sequence 0,1,2,3,0,1,2,3.
//     -> Non-RR build: out_id 0 every cycle.
//  4. Output full with out_ready=0 for 3 cycles while in_valid=4'hF
//     -> in_ready=0 throughout; out_data and out_id stable.
//     -> Raise out_ready: drain and new capture occur in the same cycle.
//  5. Full stream: in_valid=4'b1000, out_ready=1, data 1,2,3
//     -> out_data 1,2,3 on consecutive cycles, no bubble.
//  6. Reset pulse while out_valid=1 and out_ready=0
//     -> next cycle out_valid=0; RR ptr=0, so in_valid=4'hF grants channel 0 first.

Source files
------------

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel registered stream multiplexer with internal arbitration.
// Accepts one word per cycle from the granted channel into a single output
// register (1-cycle latency, full throughput under valid/ready handshakes).
// Build option: define STREAM_MUX_ARB_RR_EN for round-robin arbitration;
// when it is undefined, fixed priority is used (lowest index wins).
module stream_mux_arb #(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 4,
    localparam int ID_W   = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [ID_W-1:0]          out_id,
    input  logic                     out_ready
);

    logic            slot_free;
    logic            take;
    logic [ID_W-1:0] grant;
    logic            grant_ok;

    // The output register can accept a word when it is empty or being drained.
    assign slot_free = !out_valid || out_ready;

`ifdef STREAM_MUX_ARB_RR_EN
    logic [ID_W-1:0] ptr;
    logic [ID_W:0]   cand_sum;
    logic [ID_W-1:0] cand;

    // Round-robin grant: first requesting channel scanning ptr, ptr+1, ... modulo N_CH.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand_sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand_sum >= (ID_W+1)'(N_CH)) begin
                cand_sum = cand_sum - (ID_W+1)'(N_CH);
            end
            cand = cand_sum[ID_W-1:0];
            if (!grant_ok && in_valid[cand]) begin
                grant    = cand;
                grant_ok = 1'b1;
            end
        end
    end

    // Priority pointer moves just past the channel that completed a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (take) begin
            if (grant == ID_W'(N_CH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant + ID_W'(1);
            end
        end
    end
`else
    // Fixed-priority grant: lowest-index requesting channel wins.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (!grant_ok && in_valid[k]) begin
                grant    = ID_W'(k);
                grant_ok = 1'b1;
            end
        end
    end
`endif

    // Only the granted, requesting channel sees ready; nothing is accepted during reset.
    always_comb begin
        in_ready = '0;
        if (!rst && slot_free && grant_ok) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign take = |in_ready;

    // Output register: capture on an input transfer, clear valid on a pure drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant*DATA_W +: DATA_W];
            out_id    <= grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed scoreboard bench for stream_mux_arb (N_CH=4, DATA_W=4).
// Expected output words are queued when stimulus is issued; a monitor pops
// and compares on every output handshake. Honours STREAM_MUX_ARB_RR_EN.
module tb_stream_mux_arb;

`ifdef STREAM_MUX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] id;
    } word_t;

    word_t sb[$];

    stream_mux_arb #(.N_CH(4), .DATA_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic [1:0] id);
        word_t w;
        w.data = d;
        w.id   = id;
        sb.push_back(w);
    endtask

    // Monitor: every output handshake must match the oldest queued word.
    always @(negedge clk) begin
        word_t w;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got data=%0h id=%0d with empty queue", out_data, out_id);
            end else begin
                w = sb.pop_front();
                chk("mon_data", 32'(out_data), 32'(w.data));
                chk("mon_id", 32'(out_id), 32'(w.id));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] eid;
        logic [3:0] edat;

        // Reset with all channels requesting
        rst = 1'b1; in_valid = 4'hF; in_data = 16'hBA98; out_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();

        // Single request on channel 2
        rst = 1'b0; in_valid = 4'b0100; in_data = 16'h0A00; out_ready = 1'b1;
        push(4'hA, 2'd2);
        @(negedge clk);
        chk("single_in_ready", 32'(in_ready), 32'b0100);
        tick();
        in_valid = 4'b0000;
        @(negedge clk);
        chk("single_out_valid", 32'(out_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("single_drained", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick();

        // All channels requesting, consumer always ready
        rst = 1'b0; in_valid = 4'hF; in_data = 16'hBA98; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            eid = RR ? 2'(k % 4) : 2'd0;
            push(4'(8 + eid), eid);
            @(negedge clk);
            chk("arb_in_ready", 32'(in_ready), 32'(4'b0001 << eid));
            if (k > 0) chk("arb_no_bubble", 32'(out_valid), 32'd1);
            tick();
        end
        in_valid = 4'b0000;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("arb_drained", 32'(out_valid), 32'd0);
        tick();

        // Backpressure: fill the slot, hold three cycles, then release
        in_valid = 4'hF; out_ready = 1'b0;
        push(4'h8, 2'd0);
        @(negedge clk);
        chk("bp_first_ready", 32'(in_ready), 32'b0001);
        tick();
        in_data = 16'h7654;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h8);
            chk("bp_out_id", 32'(out_id), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        eid  = RR ? 2'd1 : 2'd0;
        edat = RR ? 4'h5 : 4'h4;
        push(edat, eid);
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'(4'b0001 << eid));
        tick();
        in_valid = 4'b0000;
        @(negedge clk);
        chk("bp_swap_valid", 32'(out_valid), 32'd1);
        chk("bp_swap_data", 32'(out_data), 32'(edat));
        tick();
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);
        tick();

        // Back-to-back stream from channel 3
        in_valid = 4'b1000; out_ready = 1'b1;
        for (int d = 1; d <= 3; d++) begin
            in_data = {4'(d), 12'h000};
            push(4'(d), 2'd3);
            @(negedge clk);
            chk("stream_in_ready", 32'(in_ready), 32'b1000);
            if (d > 1) chk("stream_no_bubble", 32'(out_valid), 32'd1);
            tick();
        end
        in_valid = 4'b0000;
        @(negedge clk);
        chk("stream_last_valid", 32'(out_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("stream_drained", 32'(out_valid), 32'd0);
        tick();

        // Reset while a word is held under backpressure; that word is discarded
        in_valid = 4'b0010; in_data = 16'h00C0; out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_ready", 32'(in_ready), 32'b0010);
        tick();
        in_valid = 4'b0000;
        @(negedge clk);
        chk("pre_rst_held", 32'(out_data), 32'hC);
        tick();
        rst = 1'b1; in_valid = 4'hF;
        @(negedge clk);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0; in_data = 16'hBA98; out_ready = 1'b1;
        push(4'h8, 2'd0);
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'b0001);
        tick();
        in_valid = 4'b0000;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("post_rst_drained", 32'(out_valid), 32'd0);
        chk("queue_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
